// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller for the 17-bit datapath: owns pc and ir,
// fetches over a req/ack handshake and resolves the next pc in EXEC.
module instr_sequencer #(
   parameter int              PC_W     = 8,
   parameter int              IW       = 17,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [IW-1:0]   imem_rdata,
   input  logic            imem_ack,
   output logic [IW-1:0]   ir,
   input  logic [1:0]      BS,
   input  logic            PS,
   input  logic            Z,
   input  logic [PC_W-1:0] br_offset,
   input  logic [PC_W-1:0] jmp_addr,
   output logic            exec_en,
   output logic            busy,
   output logic [PC_W-1:0] pc,
   output logic [15:0]     instr_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FETCH  = 2'd1,
      S_DECODE = 2'd2,
      S_EXEC   = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [IW-1:0]   ir_q, ir_d;
   logic [15:0]     cnt_q, cnt_d;

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_rel;
   logic [PC_W-1:0] next_pc;
   logic            take_branch;

   // Offset is two's complement in PC_W bits, so a plain modular add covers
   // both directions, including wrap below zero.
   assign pc_inc      = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
   assign pc_rel      = pc_q + br_offset;
   assign take_branch = Z ^ PS;

   always_comb begin
      next_pc = pc_inc;
      unique case (BS)
         2'b00: next_pc = pc_inc;
         2'b01: next_pc = take_branch ? pc_rel : pc_inc;
         2'b10: next_pc = pc_rel;
         2'b11: next_pc = jmp_addr;
         default: next_pc = pc_inc;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  if (imem_ack) state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC:   state_d = run ? S_FETCH : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      cnt_d = cnt_q;
      if ((state_q == S_FETCH) && imem_ack) begin
         ir_d = imem_rdata;
      end
      if (state_q == S_EXEC) begin
         pc_d  = next_pc;
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs decode registered state only; no input reaches an output combinationally.
   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign exec_en     = (state_q == S_EXEC);
   assign busy        = (state_q != S_IDLE);
   assign ir          = ir_q;
   assign pc          = pc_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed vector table, reset corner cases and
// randomized instructions checked against an arithmetic next-pc model.
`timescale 1ns/1ps
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst, run;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic [16:0] imem_rdata;
   logic        imem_ack;
   logic [16:0] ir;
   logic [1:0]  BS;
   logic        PS, Z;
   logic [7:0]  br_offset, jmp_addr;
   logic        exec_en, busy;
   logic [7:0]  pc;
   logic [15:0] instr_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  pc_m;
   logic [15:0] cnt_m;

   always #5 clk = ~clk;

   instr_sequencer #(.PC_W(8), .IW(17), .RESET_PC(8'h00)) dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ack(imem_ack), .ir(ir), .BS(BS), .PS(PS), .Z(Z),
      .br_offset(br_offset), .jmp_addr(jmp_addr), .exec_en(exec_en),
      .busy(busy), .pc(pc), .instr_count(instr_count)
   );

   typedef struct {
      logic [1:0]  bs;
      logic        ps;
      logic        z;
      logic [7:0]  off;
      logic [7:0]  jmp;
      int          lat;
      logic [16:0] rd;
      logic        drop;
      logic [7:0]  exp_pc;
   } vec_t;

   vec_t tbl[14];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: next pc from the branch rules using plain signed integer math.
   function automatic logic [7:0] model_next(input logic [7:0] p, input logic [1:0] bs,
                                             input logic ps, input logic z,
                                             input logic [7:0] off, input logic [7:0] jmp);
      int o, r;
      o = int'(off);
      if (o > 127) o = o - 256;
      case (bs)
         2'b00:   r = int'(p) + 1;
         2'b01:   r = (z != ps) ? int'(p) + o : int'(p) + 1;
         2'b10:   r = int'(p) + o;
         default: r = int'(jmp);
      endcase
      r = ((r % 256) + 256) % 256;
      return r[7:0];
   endfunction

   // Called with the DUT in its first FETCH cycle; walks one instruction.
   task automatic do_instr(input logic [1:0] bs_v, input logic ps_v, input logic z_v,
                           input logic [7:0] off_v, input logic [7:0] jmp_v, input int lat,
                           input logic [16:0] rd, input logic drop, input logic [7:0] exp_pc);
      BS = bs_v; PS = ps_v; Z = z_v; br_offset = off_v; jmp_addr = jmp_v;
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", 32'(imem_addr), 32'(pc_m));
      for (int i = 0; i < lat; i++) begin
         imem_ack = 1'b0;
         imem_rdata = 17'($urandom);
         step();
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", 32'(imem_addr), 32'(pc_m));
         chk("wait_exec", 32'(exec_en), 32'd0);
      end
      imem_ack = 1'b1;
      imem_rdata = rd;
      step();
      // ack stays high with junk data through DECODE/EXEC; it must be ignored
      imem_rdata = ~rd;
      chk("dec_req", 32'(imem_req), 32'd0);
      chk("dec_exec", 32'(exec_en), 32'd0);
      chk("dec_ir", 32'(ir), 32'(rd));
      chk("dec_busy", 32'(busy), 32'd1);
      if (drop) run = 1'b0;
      step();
      chk("exec_en", 32'(exec_en), 32'd1);
      chk("exec_req", 32'(imem_req), 32'd0);
      chk("exec_pc", 32'(pc), 32'(pc_m));
      step();
      imem_ack = 1'b0;
      pc_m  = exp_pc;
      cnt_m = cnt_m + 16'd1;
      chk("next_pc", 32'(pc), 32'(pc_m));
      chk("count", 32'(instr_count), 32'(cnt_m));
      chk("exec_done", 32'(exec_en), 32'd0);
      chk("ir_hold", 32'(ir), 32'(rd));
      chk("after_req", 32'(imem_req), run ? 32'd1 : 32'd0);
      chk("after_busy", 32'(busy), run ? 32'd1 : 32'd0);
   endtask

   task automatic idle_resume();
      for (int i = 0; i < 2; i++) begin
         step();
         chk("idle_busy", 32'(busy), 32'd0);
         chk("idle_req", 32'(imem_req), 32'd0);
         chk("idle_pc", 32'(pc), 32'(pc_m));
      end
      run = 1'b1;
      step();
      chk("resume_req", 32'(imem_req), 32'd1);
      chk("resume_addr", 32'(imem_addr), 32'(pc_m));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  r_bs;
      logic        r_ps, r_z, r_drop;
      logic [7:0]  r_off, r_jmp, r_exp;
      logic [16:0] r_rd;
      int          r_lat;

      tbl[0]  = '{2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 17'h0D8E4, 1'b0, 8'h01};
      tbl[1]  = '{2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 2, 17'h1A5A5, 1'b0, 8'h02};
      tbl[2]  = '{2'b10, 1'b0, 1'b0, 8'hFD, 8'h00, 0, 17'h00123, 1'b1, 8'hFF};
      tbl[3]  = '{2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1, 17'h1FFFF, 1'b0, 8'h00};
      tbl[4]  = '{2'b11, 1'b0, 1'b0, 8'h00, 8'h10, 0, 17'h00001, 1'b0, 8'h10};
      tbl[5]  = '{2'b01, 1'b0, 1'b1, 8'hFC, 8'h00, 0, 17'h10002, 1'b0, 8'h0C};
      tbl[6]  = '{2'b11, 1'b0, 1'b0, 8'h00, 8'h10, 0, 17'h00003, 1'b0, 8'h10};
      tbl[7]  = '{2'b01, 1'b0, 1'b0, 8'hFC, 8'h00, 3, 17'h00004, 1'b0, 8'h11};
      tbl[8]  = '{2'b11, 1'b0, 1'b0, 8'h00, 8'h10, 0, 17'h00005, 1'b0, 8'h10};
      tbl[9]  = '{2'b01, 1'b1, 1'b0, 8'hFC, 8'h00, 0, 17'h00006, 1'b0, 8'h0C};
      tbl[10] = '{2'b01, 1'b1, 1'b1, 8'hFC, 8'h00, 0, 17'h00007, 1'b0, 8'h0D};
      tbl[11] = '{2'b11, 1'b0, 1'b0, 8'h00, 8'hA5, 0, 17'h00008, 1'b0, 8'hA5};
      tbl[12] = '{2'b11, 1'b0, 1'b0, 8'h00, 8'hFF, 1, 17'h00009, 1'b0, 8'hFF};
      tbl[13] = '{2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 0, 17'h0000A, 1'b0, 8'h00};

      BS = 2'b00; PS = 1'b0; Z = 1'b0; br_offset = 8'h00; jmp_addr = 8'h00;
      rst = 1'b1; run = 1'b1; imem_ack = 1'b1; imem_rdata = 17'h15555;
      step();
      step();
      chk("rst_pc", 32'(pc), 32'h00);
      chk("rst_ir", 32'(ir), 32'h0);
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_exec", 32'(exec_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      rst = 1'b0; imem_ack = 1'b0;
      step();
      chk("start_req", 32'(imem_req), 32'd1);
      chk("start_addr", 32'(imem_addr), 32'h00);

      // reset wins over an ack in the same FETCH cycle
      rst = 1'b1; imem_ack = 1'b1; imem_rdata = 17'h1ABCD;
      step();
      chk("midrst_ir", 32'(ir), 32'h0);
      chk("midrst_pc", 32'(pc), 32'h00);
      chk("midrst_count", 32'(instr_count), 32'd0);
      chk("midrst_req", 32'(imem_req), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      rst = 1'b0; imem_ack = 1'b0;
      step();
      chk("restart_req", 32'(imem_req), 32'd1);

      pc_m = 8'h00;
      cnt_m = 16'd0;
      for (int i = 0; i < 14; i++) begin
         do_instr(tbl[i].bs, tbl[i].ps, tbl[i].z, tbl[i].off, tbl[i].jmp,
                  tbl[i].lat, tbl[i].rd, tbl[i].drop, tbl[i].exp_pc);
         $display("vec %0d: BS=%b PS=%b Z=%b lat=%0d -> pc=%02h count=%0d",
                  i, tbl[i].bs, tbl[i].ps, tbl[i].z, tbl[i].lat, pc, instr_count);
         if (tbl[i].drop) idle_resume();
      end

      for (int i = 0; i < 150; i++) begin
         r_bs   = 2'($urandom);
         r_ps   = 1'($urandom);
         r_z    = 1'($urandom);
         r_off  = 8'($urandom);
         r_jmp  = 8'($urandom);
         r_lat  = int'($urandom_range(0, 3));
         r_rd   = 17'($urandom);
         r_drop = ($urandom_range(0, 9) == 0);
         r_exp  = model_next(pc_m, r_bs, r_ps, r_z, r_off, r_jmp);
         do_instr(r_bs, r_ps, r_z, r_off, r_jmp, r_lat, r_rd, r_drop, r_exp);
         $display("rnd %0d: BS=%b PS=%b Z=%b off=%02h jmp=%02h lat=%0d -> pc=%02h count=%0d",
                  i, r_bs, r_ps, r_z, r_off, r_jmp, r_lat, pc, instr_count);
         if (r_drop) idle_resume();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle fetch/decode/execute controller for the 17-bit single-issue datapath. It owns the program counter and instruction register. It fetches from instruction memory with a req/ack handshake and presents the held instruction to the instruction decoder. It strobes a one-cycle execute enable, then resolves the next PC from the decoder's branch-select (BS) and polarity-select (PS) fields and the ALU zero flag.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- IW, 17, instruction width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- run  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address, equal to pc while imem_req=1
- imem_rdata  in  IW  fetched instruction, valid when imem_ack=1
- imem_ack  in  1  fetch complete
- ir  out  IW  instruction register, drives decoder Instruction_in
- BS  in  2  decoder branch select
- PS  in  1  decoder branch polarity
- Z  in  1  ALU zero flag, sampled in EXEC
- br_offset  in  PC_W  two's-complement PC-relative offset from the decoded instruction
- jmp_addr  in  PC_W  absolute jump target (register bus)
- exec_en  out  1  one-cycle strobe; gates register-file write (RW) and memory write (MW)
- busy  out  1  1 in every state except IDLE
- pc  out  PC_W  current program counter
- instr_count  out  16  retired-instruction counter

## Operation
- FSM states: IDLE, FETCH, DECODE, EXEC. All outputs are functions of registered state only; there are no combinational input-to-output paths.
- IDLE: imem_req=0, busy=0. If run=1, go to FETCH.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack=1, load ir <= imem_rdata and go to DECODE. Otherwise hold, with no timeout.
- DECODE: one cycle for the decoder outputs to settle from ir. Always go to EXEC.
- EXEC: exec_en=1 for exactly this cycle. pc <= next_pc and instr_count <= instr_count+1 (wraps 0xFFFF->0). If run=1, go to FETCH; else go to IDLE.
- next_pc, all arithmetic modulo 2^PC_W:
  - BS=00: pc+1
  - BS=01: pc+br_offset if (Z XOR PS)=1, else pc+1. PS=0 branches on zero; PS=1 branches on non-zero.
  - BS=10: pc+br_offset, unconditional
  - BS=11: jmp_addr
- br_offset is sign-extended within PC_W bits. A negative offset may wrap below 0.
- ir holds its value from the ack cycle until the next ack. It is never cleared except by reset.
- imem_ack is ignored in all states except FETCH.
- run is sampled only in IDLE and in EXEC. Deasserting run mid-instruction completes that instruction.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, ir=0, imem_req=0, exec_en=0, busy=0, instr_count=0.
- rst has priority over every other input, including an imem_ack in the same cycle. A fetch in flight is abandoned and imem_req is low the cycle after the reset edge.
- Handshake: imem_req rises on the first FETCH cycle and stays high until and including the ack cycle. It is low in the following cycle (DECODE). imem_addr is stable while imem_req=1.
- Minimum instruction time is 3 cycles (ack in the first FETCH cycle). Each cycle of ack latency adds one cycle.
- Back-to-back with run=1: EXEC is followed directly by FETCH of the new pc. imem_req is low only during DECODE and EXEC.
- pc and instr_count update on the clock edge ending EXEC. Their new values are visible in the following FETCH/IDLE cycle.
- Start latency: run rising in IDLE gives imem_req=1 on the next cycle.

## Test plan
- Reset: assert rst for 2 cycles with run=1 and imem_ack=1 -> all outputs at reset values, pc=0x00. First imem_req is seen 1 cycle after rst falls.
- Straight-line: run=1, BS=00, ack latency 0 then 2 -> instructions retire every 3 then 5 cycles. pc advances 0,1,2. exec_en is a single-cycle pulse per instruction. ir equals the returned rdata (e.g. 17'h0D8E4).
- Conditional branch: pc=0x10, br_offset=0xFC (-4). BS=01, PS=0, Z=1 -> pc=0x0C. BS=01, PS=0, Z=0 -> pc=0x11. BS=01, PS=1, Z=0 -> pc=0x0C.
- Jump and wrap: BS=11, jmp_addr=0xA5 -> pc=0xA5. At pc=0xFF with BS=00 -> pc=0x00. At pc=0x02, BS=10, br_offset=0xFD -> pc=0xFF.
- Run control: drop run during DECODE -> that instruction's EXEC still occurs, then IDLE with busy=0 and imem_req=0. Raise run again -> fetch resumes at the updated pc.
- Reset mid-fetch: assert rst in FETCH on the same cycle as imem_ack -> ir stays 0, pc=RESET_PC, instr_count unchanged at 0, state IDLE.
